// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates RISC-V branch conditions, flags mispredictions, keeps branch statistics.
// Latency: STAGES cycles (1 or 2) from input transfer to out_valid.
// Backpressure: the whole pipeline holds while out_valid && !out_ready; flush drops all in-flight work.
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           cond,
    input  logic                 pred_taken,
    input  logic                 flush,
    input  logic                 clr_stats,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 taken,
    output logic                 mispredict,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    logic                 w_enable;
    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic                 w_ev_valid;
    logic [WIDTH-1:0]     w_ev_a;
    logic [WIDTH-1:0]     w_ev_b;
    logic [2:0]           w_ev_cond;
    logic                 w_ev_pred;
    logic                 w_taken;
    logic                 w_illegal;
    logic                 w_mispredict;
    logic                 r_out_valid;
    logic                 r_taken;
    logic                 r_mispredict;
    logic                 r_illegal;
    logic [CNT_WIDTH-1:0] r_branch_count;
    logic [CNT_WIDTH-1:0] r_mispredict_count;

    // A single advance enable moves every stage together, so a stalled output freezes the pipe.
    assign w_enable   = !r_out_valid || out_ready;
    assign in_ready   = !reset && w_enable && !flush;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    generate
        if (STAGES == 2) begin : g_two
            logic             r_s1_valid;
            logic [WIDTH-1:0] r_s1_a;
            logic [WIDTH-1:0] r_s1_b;
            logic [2:0]       r_s1_cond;
            logic             r_s1_pred;

            // Operand stage: capture the request on advance; flush empties it
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1_valid <= 1'b0;
                end else if (flush) begin
                    r_s1_valid <= 1'b0;
                end else if (w_enable) begin
                    r_s1_valid <= w_in_xfer;
                    r_s1_a     <= a;
                    r_s1_b     <= b;
                    r_s1_cond  <= cond;
                    r_s1_pred  <= pred_taken;
                end
            end

            assign w_ev_valid = r_s1_valid;
            assign w_ev_a     = r_s1_a;
            assign w_ev_b     = r_s1_b;
            assign w_ev_cond  = r_s1_cond;
            assign w_ev_pred  = r_s1_pred;
        end else begin : g_one
            assign w_ev_valid = w_in_xfer;
            assign w_ev_a     = a;
            assign w_ev_b     = b;
            assign w_ev_cond  = cond;
            assign w_ev_pred  = pred_taken;
        end
    endgenerate

    // Condition evaluation over the full operand width; reserved funct3 codes are flagged illegal
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (w_ev_cond)
            3'b000:  w_taken = (w_ev_a == w_ev_b);
            3'b001:  w_taken = (w_ev_a != w_ev_b);
            3'b100:  w_taken = ($signed(w_ev_a) <  $signed(w_ev_b));
            3'b101:  w_taken = ($signed(w_ev_a) >= $signed(w_ev_b));
            3'b110:  w_taken = (w_ev_a <  w_ev_b);
            3'b111:  w_taken = (w_ev_a >= w_ev_b);
            default: w_illegal = 1'b1;
        endcase
        w_mispredict = !w_illegal && (w_taken ^ w_ev_pred);
    end

    // Result stage: fields load only with a new valid result so they stay stable under stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_enable) begin
                r_out_valid <= w_ev_valid;
            end
            if (w_enable && w_ev_valid && !flush) begin
                r_taken      <= w_taken;
                r_mispredict <= w_mispredict;
                r_illegal    <= w_illegal;
            end
        end
    end

    // Statistics: count legal delivered results, saturating; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || clr_stats) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_out_xfer && !r_illegal) begin
            if (r_branch_count != '1) begin
                r_branch_count <= r_branch_count + CNT_WIDTH'(1);
            end
            if (r_mispredict && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign taken            = r_taken;
    assign mispredict       = r_mispredict;
    assign illegal          = r_illegal;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: two instances (STAGES=1/CNT_WIDTH=16 and STAGES=2/CNT_WIDTH=4).
// Each instance has its own driver pushing expected results and a monitor popping and comparing them.
// Directed scenarios are followed by a randomized phase with random backpressure, flush and clear.
module tb_branch_resolve_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
        logic        p;
    } req_t;

    task automatic check(input int inst, input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL [u%0d] %s: got %0d expected %0d", inst, name, act, exp);
    endtask

    // Reference: {taken, mispredict, illegal}, computed with 64-bit integer arithmetic
    function automatic logic [2:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                             input logic [2:0] c, input logic p);
        longint ux, uy, sx, sy;
        logic   t;
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        sx = (ux >= 64'h8000_0000) ? ux - 64'h1_0000_0000 : ux;
        sy = (uy >= 64'h8000_0000) ? uy - 64'h1_0000_0000 : uy;
        if (c == 3'd2 || c == 3'd3) return 3'b001;
        if (c == 3'd0)      t = (ux == uy);
        else if (c == 3'd1) t = (ux != uy);
        else if (c == 3'd4) t = (sx <  sy);
        else if (c == 3'd5) t = (sx >= sy);
        else if (c == 3'd6) t = (ux <  uy);
        else                t = (ux >= uy);
        return {t, t ^ p, 1'b0};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom % 5)
            0:       return $urandom;
            1:       return 32'($urandom % 4);
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return 32'h7FFF_FFFF;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int     ST   = g + 1;
        localparam int     CW   = (g == 0) ? 16 : 4;
        localparam longint CMAX = (64'd1 << CW) - 1;

        logic          reset, in_valid, in_ready, pred, flush, clr;
        logic          out_valid, out_ready, taken, mis, ill;
        logic [31:0]   a, b;
        logic [2:0]    cond;
        logic [CW-1:0] bc, mc;
        logic          fin = 1'b0;

        logic [2:0]    exp_q[$];
        req_t          reqs[$];
        longint        m_bc, m_mc;

        branch_resolve_unit #(.WIDTH(32), .STAGES(ST), .CNT_WIDTH(CW)) dut (
            .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .cond(cond), .pred_taken(pred), .flush(flush), .clr_stats(clr),
            .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .mispredict(mis),
            .illegal(ill), .branch_count(bc), .mispredict_count(mc)
        );

        // Present the head request for one cycle; push its expected result if it transfers
        task automatic step(input int exp_ov);
            req_t r;
            if (reqs.size() > 0) begin
                in_valid = 1'b1;
                {a, b, cond, pred} = reqs[0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check(g, "in_ready", in_ready, reset ? 1'b0 : ((!out_valid || out_ready) && !flush));
            if (exp_ov >= 0) check(g, "latency_out_valid", out_valid, exp_ov[0]);
            if (in_valid && in_ready) begin
                r = reqs.pop_front();
                exp_q.push_back(ref_model(r.a, r.b, r.c, r.p));
            end
            @(posedge clk);
            #1;
        endtask

        task automatic drain();
            for (int k = 0; k < 300 && (reqs.size() > 0 || exp_q.size() > 0); k++) begin
                out_ready = 1'b1; flush = 1'b0; clr = 1'b0;
                step(-1);
            end
            check(g, "drain_timeout", reqs.size() + exp_q.size(), 0);
        endtask

        // Monitor: compare delivered results, stall stability and the counter model
        initial begin
            logic       p_stall;
            logic [2:0] p_f, e;
            p_stall = 1'b0; p_f = 3'b0; m_bc = 0; m_mc = 0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    exp_q.delete();
                    m_bc = 0; m_mc = 0; p_stall = 1'b0;
                end else begin
                    if (out_valid) check(g, "out_valid_has_expected", exp_q.size() > 0, 1);
                    if (p_stall) check(g, "stall_hold", {out_valid, taken, mis, ill}, {1'b1, p_f});
                    check(g, "branch_count", bc, m_bc);
                    check(g, "mispredict_count", mc, m_mc);
                    if (out_valid && out_ready && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check(g, "result_taken_mis_ill", {taken, mis, ill}, e);
                        if (!e[0]) begin
                            m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
                            if (e[1]) m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
                        end
                    end
                    if (clr) begin m_bc = 0; m_mc = 0; end
                    if (flush) exp_q.delete();
                    p_stall = out_valid && !out_ready && !flush;
                    p_f     = {taken, mis, ill};
                end
            end
        end

        // Driver
        initial begin
            logic [63:0] bc0;
            reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cond = '0; pred = 1'b0;
            flush = 1'b0; clr = 1'b0; out_ready = 1'b1;
            repeat (3) step(-1);
            reset = 1'b0;
            step(0);
            check(g, "reset_branch_count", bc, 0);
            check(g, "reset_mispredict_count", mc, 0);

            // BEQ 0x0F vs 0x55 predicted taken: not taken, mispredict, arrives after ST cycles
            reqs.push_back(req_t'{32'h0F, 32'h55, 3'b000, 1'b1});
            step(0);
            for (int k = 1; k <= ST; k++) step((k == ST) ? 1 : 0);
            drain();
            check(g, "first_branch_count", bc, 1);
            check(g, "first_mispredict_count", mc, 1);

            // Signed vs unsigned ordering with -1 vs 1
            reqs.push_back(req_t'{32'hFFFF_FFFF, 32'h1, 3'b100, 1'b0});
            reqs.push_back(req_t'{32'hFFFF_FFFF, 32'h1, 3'b110, 1'b0});
            reqs.push_back(req_t'{32'hFFFF_FFFF, 32'h1, 3'b101, 1'b0});
            reqs.push_back(req_t'{32'hFFFF_FFFF, 32'h1, 3'b111, 1'b0});
            // Reserved codes never count
            reqs.push_back(req_t'{$urandom, $urandom, 3'b011, 1'b1});
            reqs.push_back(req_t'{32'h5, 32'h5, 3'b010, 1'b0});
            drain();
            check(g, "after_signed_illegal_bc", bc, 5);
            check(g, "after_signed_illegal_mc", mc, 3);

            // Three back-to-back requests against a blocked consumer
            reqs.push_back(req_t'{32'h7, 32'h7, 3'b000, 1'b0});
            reqs.push_back(req_t'{32'h1, 32'h2, 3'b001, 1'b0});
            reqs.push_back(req_t'{32'h9, 32'h3, 3'b110, 1'b1});
            for (int c = 0; c < 8; c++) begin
                out_ready = (c >= 4);
                step(-1);
            end
            drain();

            // Flush with work in flight; a held request goes in right after
            bc0 = 64'(bc);
            reqs.push_back(req_t'{32'h1, 32'h1, 3'b000, 1'b0});
            reqs.push_back(req_t'{32'h2, 32'h1, 3'b101, 1'b0});
            out_ready = 1'b0;
            step(-1);
            step(-1);
            reqs.push_back(req_t'{32'h3, 32'h4, 3'b100, 1'b0});
            flush = 1'b1;
            step(-1);
            flush = 1'b0;
            reqs.delete();
            reqs.push_back(req_t'{32'h3, 32'h4, 3'b100, 1'b0});
            step(0);
            check(g, "accept_after_flush", reqs.size(), 0);
            check(g, "flush_counts_unchanged", bc, bc0);
            drain();

            // Randomized traffic
            for (int c = 0; c < 500; c++) begin
                if (reqs.size() == 0 && ($urandom % 10) < 6) begin
                    req_t r;
                    r.a = rand_op();
                    r.b = (($urandom % 4) == 0) ? r.a : rand_op();
                    r.c = 3'($urandom);
                    r.p = 1'($urandom);
                    reqs.push_back(r);
                end
                out_ready = (($urandom % 4) != 0);
                flush     = (($urandom % 20) == 0);
                clr       = (($urandom % 25) == 0);
                step(-1);
            end
            flush = 1'b0; clr = 1'b0;
            drain();

            // Saturation with 20 mispredicting BNEs
            clr = 1'b1;
            step(-1);
            clr = 1'b0;
            for (int i = 0; i < 20; i++) reqs.push_back(req_t'{32'(i + 1), 32'h0, 3'b001, 1'b0});
            drain();
            check(g, "saturate_branch_count", bc, (CMAX < 20) ? CMAX : 20);
            check(g, "saturate_mispredict_count", mc, (CMAX < 20) ? CMAX : 20);

            // Clear coinciding with a counted transfer
            reqs.push_back(req_t'{32'h1, 32'h0, 3'b001, 1'b0});
            out_ready = 1'b0;
            for (int k = 0; k < 10 && !out_valid; k++) step(-1);
            check(g, "clr_setup_out_valid", out_valid, 1);
            out_ready = 1'b1; clr = 1'b1;
            step(-1);
            clr = 1'b0;
            check(g, "clr_wins_branch_count", bc, 0);
            check(g, "clr_wins_mispredict_count", mc, 0);

            // Reset with requests in flight
            reqs.push_back(req_t'{32'h1, 32'h0, 3'b001, 1'b0});
            drain();
            reqs.push_back(req_t'{32'h4, 32'h4, 3'b000, 1'b0});
            reqs.push_back(req_t'{32'h4, 32'h5, 3'b000, 1'b1});
            out_ready = 1'b0;
            step(-1);
            step(-1);
            reset = 1'b1;
            reqs.delete();
            step(-1);
            reset = 1'b0;
            step(0);
            check(g, "reset_midflight_bc", bc, 0);
            check(g, "reset_midflight_mc", mc, 0);
            drain();
            fin = 1'b1;
        end
    end

    initial begin
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk);
            if (inst[0].fin && inst[1].fin) break;
        end
        if (!(inst[0].fin && inst[1].fin)) check(0, "overall_timeout", {inst[1].fin, inst[0].fin}, 3);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits (legal 8..64).
REQ-002 Parameter STAGES, default 1, result latency in cycles (legal 1 or 2).
REQ-003 Parameter CNT_WIDTH, default 16, width of each statistics counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  branch request present.
REQ-007 in_ready  output  1  unit accepts a request this cycle.
REQ-008 a, b  input  WIDTH each  rs1 and rs2 operand values.
REQ-009 cond  input  3  funct3 code: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 illegal.
REQ-010 pred_taken  input  1  front-end prediction for this branch.
REQ-011 flush  input  1  discard all in-flight requests.
REQ-012 clr_stats  input  1  zero both statistics counters.
REQ-013 out_valid  output  1  registered result present.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 taken, mispredict, illegal  output  1 each  registered result fields.
REQ-016 branch_count, mispredict_count  output  CNT_WIDTH each  statistics.

Function
REQ-017 Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 Pipeline advance enable = !out_valid || out_ready; in_ready = enable && !flush.
REQ-019 taken: BEQ a==b; BNE a!=b; BLT signed a<b; BGE signed a>=b; BLTU unsigned a<b; BGEU unsigned a>=b, all over full WIDTH.
REQ-020 Illegal cond: taken=0, mispredict=0, illegal=1; otherwise illegal=0.
REQ-021 mispredict = taken XOR pred_taken for legal cond.
REQ-022 STAGES=1: result registered on input transfer; out_valid rises the next cycle.
REQ-023 STAGES=2: stage 1 registers operands, cond and pred_taken; stage 2 registers result; out_valid rises two cycles after input transfer; with both stages occupied and out_ready=1, throughput is one result per cycle.
REQ-024 When enable=0, all stage registers and outputs hold unchanged (no loss, no duplication).
REQ-025 Result fields are stable whenever out_valid=1 and out_ready=0.
REQ-026 flush clears every stage valid bit at the clock edge; an output transfer in the flush cycle still completes and is counted.
REQ-027 On each output transfer with illegal=0, branch_count increments by 1; mispredict_count also increments if mispredict=1.
REQ-028 Illegal results increment neither counter.
REQ-029 Counters saturate at 2^CNT_WIDTH-1; no wrap-around.
REQ-030 clr_stats zeroes both counters at the edge; wins over a simultaneous increment.
REQ-031 in_valid with in_ready=0 has no effect; the source must hold the request.

Reset
REQ-032 reset clears all stage valid bits, out_valid, taken, mispredict, illegal, branch_count and mispredict_count to 0.
REQ-033 reset wins over flush, clr_stats and any transfer in the same cycle; in-flight requests are discarded.
REQ-034 in_ready is 0 while reset is high and 1 on the first cycle after reset deassertion.

Verification
REQ-035 STAGES=1, BEQ a=0x0F b=0x55 pred=1 -> next cycle out_valid=1, taken=0, mispredict=1, branch_count=1, mispredict_count=1.
REQ-036 BLT vs BLTU with a=0xFFFFFFFF b=0x1 -> BLT taken=1, BLTU taken=0; BGE taken=0, BGEU taken=1.
REQ-037 STAGES=2, three back-to-back requests with out_ready=0 for 3 cycles -> in_ready=0 while full, results unchanged, then three results delivered in order on consecutive cycles once out_ready=1.
REQ-038 Flush with two requests in flight (STAGES=2) -> out_valid=0 next cycle; counters unchanged; new request accepted one cycle after flush deasserts.
REQ-039 CNT_WIDTH=4, 20 mispredicting BNE transfers -> both counters stop at 15; clr_stats coinciding with a transfer -> both counters 0.
REQ-040 cond=011 with pred_taken=1 -> illegal=1, taken=0, mispredict=0, counters unchanged.
